// File: rtl/aib_rx_pkg.sv
// Shared constants and types for the AIB receive deframer: beat field
// positions, half/word widths and the half-beat assembly states.
package aib_rx_pkg;

  localparam int BEAT_W      = 40;
  localparam int BEAT_VALID  = 39;
  localparam int BEAT_PHASE  = 38;
  localparam int BEAT_FSFULL = 37;
  localparam int BEAT_RSVD   = 36;
  localparam int HALF_W      = 36;
  localparam int WORD_W      = 72;

  typedef enum logic {
    ASM_IDLE,
    ASM_HALF
  } asm_state_e;

endpackage

// File: rtl/aib_rx_deframer_if.sv
// Core-side word handshake of the AIB receive deframer (valid/ready/data).
interface aib_rx_deframer_if;
  import aib_rx_pkg::*;

  logic              rx_valid;
  logic              rx_ready;
  logic [WORD_W-1:0] rx_data;

  modport master (output rx_valid, output rx_data, input rx_ready);
  modport slave  (input rx_valid, input rx_data, output rx_ready);

endinterface

// File: rtl/aib_rx_sync_fifo.sv
// First-word-fall-through synchronous FIFO; reports post-edge occupancy and
// whether the offered push is taken (a same-edge pop frees room when full).
module aib_rx_sync_fifo #(
  parameter  int WIDTH = 72,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             push_ok,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    occ_nxt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;

  assign valid   = (count_q != '0);
  assign do_pop  = pop & valid;
  assign push_ok = push & ((count_q < CW'(DEPTH)) | do_pop);
  assign occ_nxt = count_q + CW'(push_ok) - CW'(do_pop);
  // Head is forced to zero while empty so the word bus reads 0 out of reset.
  assign rdata   = valid ? mem[rptr_q] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_q + AW'(push_ok);
      rptr_q  <= rptr_q + AW'(do_pop);
      count_q <= occ_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/aib_rx_deframer.sv
// AIB far-side receive deframer: registers each 40-bit beat, pairs phase-0/1
// halves into 72-bit words, buffers them and tracks sequence/overflow errors.
module aib_rx_deframer
  import aib_rx_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                      i_aib_clk,
  input  logic                      i_rst_n,
  input  logic [19:0]               i_rx_data0,
  input  logic [19:0]               i_rx_data1,
  aib_rx_deframer_if.master         rx_if,
  output logic                      o_ns_fifo_full,
  output logic                      o_fs_fifo_full,
  input  logic                      i_err_clr,
  output logic                      o_err_seq,
  output logic                      o_err_ovf,
  output logic [7:0]                o_err_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - AFULL_MARGIN);

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [BEAT_W-1:0] beat_q;
  logic              fs_full_q;
  logic              ns_full_q;
  asm_state_e        state_q, state_d;
  logic [HALF_W-1:0] held_q, held_d;
  logic [HALF_W-1:0] payload;
  logic              push, push_ok, seq_err, ovf_err;
  logic              fifo_valid;
  logic [CW-1:0]     occ_nxt;
  logic [1:0]        n_err;
  logic              err_seq_q, err_ovf_q;
  logic [7:0]        err_cnt_q;
  logic              unused_rsvd;

  assign payload     = beat_q[HALF_W-1:0];
  assign unused_rsvd = beat_q[BEAT_RSVD];

  // Input stage: capture every beat, then re-register the far-side flag
  always_ff @(posedge i_aib_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_q    <= '0;
      fs_full_q <= 1'b0;
    end else begin
      beat_q    <= {i_rx_data1, i_rx_data0};
      fs_full_q <= beat_q[BEAT_FSFULL];
    end
  end

  // Assembly stage: pair halves from beat_q
  always_ff @(posedge i_aib_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ASM_IDLE;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    push    = 1'b0;
    seq_err = 1'b0;
    if (beat_q[BEAT_VALID]) begin
      case (state_q)
        ASM_IDLE: begin
          if (beat_q[BEAT_PHASE]) begin
            seq_err = 1'b1;
          end else begin
            held_d  = payload;
            state_d = ASM_HALF;
          end
        end
        ASM_HALF: begin
          if (beat_q[BEAT_PHASE]) begin
            push    = 1'b1;
            state_d = ASM_IDLE;
          end else begin
            held_d  = payload;
            seq_err = 1'b1;
          end
        end
      endcase
    end
  end

  aib_rx_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (i_aib_clk),
    .rst_n   (i_rst_n),
    .push    (push),
    .wdata   ({payload, held_q}),
    .push_ok (push_ok),
    .pop     (rx_if.rx_ready),
    .valid   (fifo_valid),
    .rdata   (rx_if.rx_data),
    .occ_nxt (occ_nxt)
  );

  assign rx_if.rx_valid = fifo_valid;
  assign ovf_err        = push & ~push_ok;
  assign n_err          = {1'b0, seq_err} + {1'b0, ovf_err};

  // Status stage: near-full from post-edge occupancy, sticky errors and count
  always_ff @(posedge i_aib_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ns_full_q <= 1'b0;
      err_seq_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      ns_full_q <= (occ_nxt >= AFULL_LVL);
      if (i_err_clr) begin
        err_seq_q <= seq_err;
        err_ovf_q <= ovf_err;
        err_cnt_q <= {6'b0, n_err};
      end else begin
        err_seq_q <= err_seq_q | seq_err;
        err_ovf_q <= err_ovf_q | ovf_err;
        err_cnt_q <= sat_add(err_cnt_q, n_err);
      end
    end
  end

  assign o_ns_fifo_full = ns_full_q;
  assign o_fs_fifo_full = fs_full_q;
  assign o_err_seq      = err_seq_q;
  assign o_err_ovf      = err_ovf_q;
  assign o_err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_aib_rx_deframer.sv
// Bench for aib_rx_deframer: directed scenarios plus random beats, all outputs
// compared every cycle against a queue-based model of the deframer rules.
module tb_aib_rx_deframer;

  localparam int DEPTH = 8;
  localparam int AFM   = 2;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [19:0] d0      = '0;
  logic [19:0] d1      = '0;
  logic        err_clr = 1'b0;
  logic        ns_full, fs_full, err_seq, err_ovf;
  logic [7:0]  err_cnt;

  aib_rx_deframer_if rx_if ();

  aib_rx_deframer #(.DEPTH(DEPTH), .AFULL_MARGIN(AFM)) dut (
    .i_aib_clk      (clk),
    .i_rst_n        (rst_n),
    .i_rx_data0     (d0),
    .i_rx_data1     (d1),
    .rx_if          (rx_if),
    .o_ns_fifo_full (ns_full),
    .o_fs_fifo_full (fs_full),
    .i_err_clr      (err_clr),
    .o_err_seq      (err_seq),
    .o_err_ovf      (err_ovf),
    .o_err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] rnd36();
    return 36'({$urandom, $urandom});
  endfunction

  // Reference model: pending half as an optional value, FIFO as a queue.
  logic [39:0] m_beat   = '0;
  logic        m_fs     = 1'b0;
  logic        m_ns     = 1'b0;
  logic        m_pend_v = 1'b0;
  logic [35:0] m_pend   = '0;
  logic [71:0] q [$];
  logic        m_seq    = 1'b0;
  logic        m_ovf    = 1'b0;
  int          m_cnt    = 0;

  task automatic model_step();
    bit          pop, have, seq_now, ovf_now;
    logic [71:0] w;
    int          ev;
    pop     = (q.size() > 0) && rx_if.rx_ready;
    have    = 1'b0;
    seq_now = 1'b0;
    w       = '0;
    if (m_beat[39]) begin
      if (m_beat[38]) begin
        if (m_pend_v) begin
          have     = 1'b1;
          w        = {m_beat[35:0], m_pend};
          m_pend_v = 1'b0;
        end else begin
          seq_now = 1'b1;
        end
      end else begin
        if (m_pend_v) seq_now = 1'b1;
        m_pend   = m_beat[35:0];
        m_pend_v = 1'b1;
      end
    end
    ovf_now = have && !((q.size() < DEPTH) || pop);
    if (pop) void'(q.pop_front());
    if (have && !ovf_now) q.push_back(w);
    ev = int'(seq_now) + int'(ovf_now);
    if (err_clr) begin
      m_seq = seq_now;
      m_ovf = ovf_now;
      m_cnt = ev;
    end else begin
      m_seq = m_seq | seq_now;
      m_ovf = m_ovf | ovf_now;
      m_cnt = (m_cnt + ev > 255) ? 255 : m_cnt + ev;
    end
    m_ns   = (q.size() >= DEPTH - AFM);
    m_fs   = m_beat[37];
    m_beat = {d1, d0};
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_beat   = '0;
      m_fs     = 1'b0;
      m_ns     = 1'b0;
      m_pend_v = 1'b0;
      m_pend   = '0;
      q.delete();
      m_seq    = 1'b0;
      m_ovf    = 1'b0;
      m_cnt    = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    chk("valid", 72'(rx_if.rx_valid), 72'(q.size() != 0));
    if (q.size() != 0) chk("data", rx_if.rx_data, q[0]);
    chk("ns_full", 72'(ns_full), 72'(m_ns));
    chk("fs_full", 72'(fs_full), 72'(m_fs));
    chk("err_seq", 72'(err_seq), 72'(m_seq));
    chk("err_ovf", 72'(err_ovf), 72'(m_ovf));
    chk("err_cnt", 72'(err_cnt), 72'(m_cnt));
  end

  task automatic beat(input bit v, input bit ph, input bit fsb, input logic [35:0] p);
    @(negedge clk);
    {d1, d0} = {v, ph, fsb, 1'b0, p};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      {d1, d0} = '0;
    end
  endtask

  task automatic clear_errs();
    @(negedge clk);
    {d1, d0} = '0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic lit_zero(input string tag);
    chk({tag, "_valid"}, 72'(rx_if.rx_valid), 72'(0));
    chk({tag, "_data"},  rx_if.rx_data, 72'(0));
    chk({tag, "_ns"},    72'(ns_full), 72'(0));
    chk({tag, "_fs"},    72'(fs_full), 72'(0));
    chk({tag, "_seq"},   72'(err_seq), 72'(0));
    chk({tag, "_ovf"},   72'(err_ovf), 72'(0));
    chk({tag, "_cnt"},   72'(err_cnt), 72'(0));
  endtask

  logic [71:0] words [9];
  logic [35:0] lo, hi;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_if.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    lit_zero("reset");
    rst_n = 1'b1;

    // Single word, 2-cycle latency
    rx_if.rx_ready = 1'b1;
    beat(1, 0, 0, 36'h123456789);
    beat(1, 1, 0, 36'hABCDEF012);
    @(negedge clk);
    chk("lat_n_valid", 72'(rx_if.rx_valid), 72'(0));
    {d1, d0} = '0;
    @(negedge clk);
    chk("lat_n1_valid", 72'(rx_if.rx_valid), 72'(1));
    chk("single_data", rx_if.rx_data, 72'hABCDEF012_123456789);
    chk("single_cnt", 72'(err_cnt), 72'(0));
    idle(2);

    // Gap between halves
    lo = rnd36(); hi = rnd36();
    beat(1, 0, 0, lo);
    idle(3);
    beat(1, 1, 0, hi);
    idle(2);
    chk("gap_valid", 72'(rx_if.rx_valid), 72'(1));
    chk("gap_data", rx_if.rx_data, {hi, lo});
    chk("gap_cnt", 72'(err_cnt), 72'(0));
    idle(2);

    // Lone phase 1, then A,B,C
    beat(1, 1, 0, rnd36());
    idle(2);
    chk("lone_seq", 72'(err_seq), 72'(1));
    chk("lone_cnt", 72'(err_cnt), 72'(1));
    chk("lone_valid", 72'(rx_if.rx_valid), 72'(0));
    lo = rnd36(); hi = rnd36();
    beat(1, 0, 0, rnd36());
    beat(1, 0, 0, lo);
    beat(1, 1, 0, hi);
    idle(2);
    chk("abc_data", rx_if.rx_data, {hi, lo});
    chk("abc_cnt", 72'(err_cnt), 72'(2));
    idle(2);

    // Fill with ready low, 9th word dropped, then drain in order
    clear_errs();
    rx_if.rx_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      lo = rnd36(); hi = rnd36();
      words[k] = {hi, lo};
      beat(1, 0, 0, lo);
      beat(1, 1, 0, hi);
      idle(2);
      chk($sformatf("fill_ns%0d", k), 72'(ns_full), 72'(k + 1 >= DEPTH - AFM));
      chk($sformatf("fill_ovf%0d", k), 72'(err_ovf), 72'(k == 8));
    end
    rx_if.rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_data%0d", i), rx_if.rx_data, words[i]);
      @(negedge clk);
    end
    chk("drain_empty", 72'(rx_if.rx_valid), 72'(0));

    // Full with a pop on the same edge as the 9th push
    clear_errs();
    rx_if.rx_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      lo = rnd36(); hi = rnd36();
      words[k] = {hi, lo};
      beat(1, 0, 0, lo);
      beat(1, 1, 0, hi);
      if (k < 8) idle(2);
    end
    @(negedge clk);
    {d1, d0} = '0;
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
    chk("fullpop_ovf", 72'(err_ovf), 72'(0));
    chk("fullpop_ns", 72'(ns_full), 72'(1));
    rx_if.rx_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      chk($sformatf("fullpop_data%0d", i), rx_if.rx_data, words[i]);
      @(negedge clk);
    end
    chk("fullpop_empty", 72'(rx_if.rx_valid), 72'(0));

    // Counter saturation and clear-with-error
    clear_errs();
    repeat (300) beat(1, 1, 0, rnd36());
    idle(2);
    chk("sat_cnt", 72'(err_cnt), 72'(255));
    beat(1, 1, 0, rnd36());
    @(negedge clk);
    {d1, d0} = '0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_cnt", 72'(err_cnt), 72'(1));
    chk("clr_seq", 72'(err_seq), 72'(1));

    // Far-side flag lag
    beat(0, 0, 1, '0);
    @(negedge clk);
    chk("fs_lag1", 72'(fs_full), 72'(0));
    {d1, d0} = '0;
    @(negedge clk);
    chk("fs_lag2", 72'(fs_full), 72'(1));
    @(negedge clk);
    chk("fs_lag3", 72'(fs_full), 72'(0));

    // Reset mid-word
    rx_if.rx_ready = 1'b0;
    beat(1, 0, 0, rnd36());
    beat(1, 1, 0, rnd36());
    beat(1, 0, 0, rnd36());
    beat(0, 0, 1, '0);
    beat(0, 0, 1, '0);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", 72'(rx_if.rx_valid), 72'(1));
    rst_n = 1'b0;
    #1;
    lit_zero("async_rst");
    @(negedge clk);
    {d1, d0} = '0;
    rst_n = 1'b1;
    beat(1, 1, 0, rnd36());
    idle(2);
    chk("rst_seq", 72'(err_seq), 72'(1));
    chk("rst_cnt", 72'(err_cnt), 72'(1));
    chk("rst_valid", 72'(rx_if.rx_valid), 72'(0));

    // Random traffic with varying back-pressure
    for (int seg = 0; seg < 15; seg++) begin
      int bias;
      bias = $urandom_range(0, 8);
      repeat (200) begin
        @(negedge clk);
        {d1, d0} = {($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom), rnd36()};
        rx_if.rx_ready = ($urandom_range(0, 7) < bias);
        err_clr = ($urandom_range(0, 63) == 0);
      end
    end
    err_clr = 1'b0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
